valid_ready_elastic_buffer: RTL and testbench



---
 rtl/valid_ready_pkg.sv | 14 +
 rtl/valid_ready_elastic_buffer_wrapping_counter.sv | 45 ++++
 rtl/valid_ready_elastic_buffer.sv | 129 ++++++++++++
 tb/tb_valid_ready_elastic_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valid_ready_pkg.sv
// rtl/valid_ready_pkg.sv - shared sizing helpers for the valid/ready elastic buffer
package valid_ready_pkg;

    // Bits needed to count 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries; at least one bit even for depth 1..2.
    function automatic int pointer_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/valid_ready_elastic_buffer_wrapping_counter.sv
// rtl/valid_ready_elastic_buffer_wrapping_counter.sv - modulo (MAXIMUM+1) counter used for buffer pointers
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, count -> 0
//   clear      synchronous clear, count -> 0, wins over increment
//   increment  advance by one, wrapping from MAXIMUM to 0
//   count      current value
module wrapping_counter #(
    parameter int WIDTH   = 2,
    parameter int MAXIMUM = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAXIMUM);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Explicit wrap so non-power-of-two depths never reach an unused slot.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment) begin
            count_d = (count_q == COUNT_MAX) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/valid_ready_elastic_buffer.sv
// rtl/valid_ready_elastic_buffer.sv - parametrised-depth valid/ready elastic buffer with level and almost-full
//
// Optional feature macro: VALID_READY_ELASTIC_BUFFER_BYPASS_EN
//   defined   : an empty buffer forwards write_data to read_data combinationally
//   undefined : read side is always registered, one cycle behind the write side
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   flush                    synchronous clear of all entries, masks both handshakes
//   write_data/valid/ready   source side
//   read_data/valid/ready    sink side, read_data is 0 whenever read_valid is 0
//   full, empty, almost_full occupancy flags
//   level                    number of stored entries
module valid_ready_elastic_buffer
    import valid_ready_pkg::*;
#(
    parameter int WIDTH                 = 8,
    parameter int DEPTH                 = 4,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              write_data,
    input  logic                          write_valid,
    output logic                          write_ready,
    output logic [WIDTH-1:0]              read_data,
    output logic                          read_valid,
    input  logic                          read_ready,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int              LW        = level_width(DEPTH);
    localparam int              PW        = pointer_width(DEPTH);
    localparam logic [LW-1:0]   LEVEL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0]   LEVEL_AF  = LW'(ALMOST_FULL_THRESHOLD);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [PW-1:0]    read_pointer;
    logic [PW-1:0]    write_pointer;
    logic             write_fire;
    logic             read_fire;
    logic             push;
    logic             pop;

    assign full        = (level_q == LEVEL_MAX);
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= LEVEL_AF);
    assign level       = level_q;

    // Ready is a function of state and flush/reset only, never of read_ready.
    assign write_ready = !full && !flush && !reset;
    assign write_fire  = write_valid && write_ready;
    assign read_fire   = read_valid && read_ready;

`ifdef VALID_READY_ELASTIC_BUFFER_BYPASS_EN
    logic bypass;

    assign bypass     = empty && write_valid && !flush && !reset;
    assign read_valid = (!empty && !flush) || bypass;
    assign read_data  = !read_valid ? '0 :
                        (empty ? write_data : storage_q[read_pointer]);
    // A pass-through transfer is never stored, so it neither pushes nor pops.
    assign push       = write_fire && !(bypass && read_ready);
    assign pop        = read_fire && !empty;
`else
    assign read_valid = !empty && !flush;
    assign read_data  = read_valid ? storage_q[read_pointer] : '0;
    assign push       = write_fire;
    assign pop        = read_fire;
`endif

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Payload storage carries no reset; only entries below level are ever observed.
    always_ff @(posedge clock) begin
        if (push) begin
            storage_q[write_pointer] <= write_data;
        end
    end

    wrapping_counter #(
        .WIDTH   (PW),
        .MAXIMUM (DEPTH - 1)
    ) u_write_pointer (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .increment (push),
        .count     (write_pointer)
    );

    wrapping_counter #(
        .WIDTH   (PW),
        .MAXIMUM (DEPTH - 1)
    ) u_read_pointer (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .increment (pop),
        .count     (read_pointer)
    );

    level_bounded: assert property (@(posedge clock) disable iff (reset) level_q <= LEVEL_MAX);
    flags_exclusive: assert property (@(posedge clock) disable iff (reset) !(full && empty));

endmodule

// File: tb/tb_valid_ready_elastic_buffer.sv
// tb/tb_valid_ready_elastic_buffer.sv - randomized self-checking bench with queue reference model
module tb_valid_ready_elastic_buffer;

`ifdef VALID_READY_ELASTIC_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_flush = 1'b0, a_write_valid = 1'b0, a_read_ready = 1'b0;
    logic [7:0] a_write_data = 8'h00;
    logic       a_write_ready, a_read_valid, a_full, a_empty, a_almost_full;
    logic [7:0] a_read_data;
    logic [2:0] a_level;

    logic       b_flush = 1'b0, b_write_valid = 1'b0, b_read_ready = 1'b0;
    logic [7:0] b_write_data = 8'h00;
    logic       b_write_ready, b_read_valid, b_full, b_empty, b_almost_full;
    logic [7:0] b_read_data;
    logic [1:0] b_level;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clock = ~clock;

    valid_ready_elastic_buffer #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESHOLD(3)) dut_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .write_data(a_write_data), .write_valid(a_write_valid), .write_ready(a_write_ready),
        .read_data(a_read_data), .read_valid(a_read_valid), .read_ready(a_read_ready),
        .full(a_full), .empty(a_empty), .almost_full(a_almost_full), .level(a_level)
    );

    valid_ready_elastic_buffer #(.WIDTH(8), .DEPTH(3)) dut_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .write_data(b_write_data), .write_valid(b_write_valid), .write_ready(b_write_ready),
        .read_data(b_read_data), .read_valid(b_read_valid), .read_ready(b_read_ready),
        .full(b_full), .empty(b_empty), .almost_full(b_almost_full), .level(b_level)
    );

    // Expected {write_ready, read_valid, read_data, full, empty, almost_full, level}
    // derived from the occupancy of an abstract FIFO plus the current inputs.
    function automatic logic [15:0] model_status(input int depth, input int thr, input int size,
                                                 input logic [7:0] head, input logic wv,
                                                 input logic [7:0] wd, input logic fl,
                                                 input logic rst);
        logic       wr;
        logic       rv;
        logic [7:0] rd;
        wr = !rst && !fl && (size < depth);
        rv = !rst && !fl && ((size > 0) || (BYP && wv));
        rd = !rv ? 8'h00 : ((size > 0) ? head : wd);
        return {wr, rv, rd, size == depth, size == 0, size >= thr, 3'(size)};
    endfunction

    function automatic logic [15:0] exp_a();
        return model_status(4, 3, qa.size(), (qa.size() > 0) ? qa[0] : 8'h00,
                            a_write_valid, a_write_data, a_flush, reset);
    endfunction

    function automatic logic [15:0] exp_b();
        return model_status(3, 2, qb.size(), (qb.size() > 0) ? qb[0] : 8'h00,
                            b_write_valid, b_write_data, b_flush, reset);
    endfunction

    function automatic logic [15:0] obs_a();
        return {a_write_ready, a_read_valid, a_read_data, a_full, a_empty, a_almost_full, a_level};
    endfunction

    function automatic logic [15:0] obs_b();
        return {b_write_ready, b_read_valid, b_read_data, b_full, b_empty, b_almost_full, 1'b0, b_level};
    endfunction

    // Advance the reference FIFOs by the transfers implied by the current inputs, then clock.
    task automatic tick();
        bit e, w, r;
        if (!reset) begin
            e = (qa.size() == 0);
            w = a_write_valid && !a_flush && (qa.size() < 4);
            r = a_read_ready && !a_flush && (!e || (BYP && a_write_valid));
            if (a_flush) qa.delete();
            else if (!(r && e)) begin
                if (r) void'(qa.pop_front());
                if (w) qa.push_back(a_write_data);
            end
            e = (qb.size() == 0);
            w = b_write_valid && !b_flush && (qb.size() < 3);
            r = b_read_ready && !b_flush && (!e || (BYP && b_write_valid));
            if (b_flush) qb.delete();
            else if (!(r && e)) begin
                if (r) void'(qb.pop_front());
                if (w) qb.push_back(b_write_data);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        a_write_valid = wv;
        a_write_data  = wd;
        a_read_ready  = rr;
        a_flush       = fl;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (obs_a() !== exp_a() || obs_b() !== exp_b()) begin
            $display("FAIL reset_state a=%h b=%h want a=%h b=%h", obs_a(), obs_b(), exp_a(), exp_b());
            miscompares++;
        end
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        vectors++;
        if (a_write_ready !== 1'b1 || obs_a() !== exp_a()) begin
            $display("FAIL reset_release got %h want %h", obs_a(), exp_a());
            miscompares++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fill(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'(base + i), 1'b0, 1'b0);
            #1;
            vectors++;
            if (obs_a() !== exp_a()) begin
                $display("FAIL fill[%0d] got %h want %h", i, obs_a(), exp_a());
                miscompares++;
            end
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({a_level, a_full, a_write_ready, a_almost_full, a_read_valid, a_read_data} !==
            {3'd4, 1'b1, 1'b0, 1'b1, 1'b1, base}) begin
            $display("FAIL fill_full got lvl=%0d full=%b wr=%b af=%b rv=%b rd=%h want lvl=4 full=1 wr=0 af=1 rv=1 rd=%h",
                     a_level, a_full, a_write_ready, a_almost_full, a_read_valid, a_read_data, base);
            miscompares++;
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            vectors++;
            if (a_read_data !== 8'(8'hA0 + i) || obs_a() !== exp_a()) begin
                $display("FAIL drain[%0d] got %h want rd=%h status %h", i, obs_a(), 8'(8'hA0 + i), exp_a());
                miscompares++;
            end
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({a_empty, a_read_valid, a_read_data} !== {1'b1, 1'b0, 8'h00}) begin
            $display("FAIL drain_empty got empty=%b rv=%b rd=%h want 1 0 00", a_empty, a_read_valid, a_read_data);
            miscompares++;
        end
    endtask

    task automatic test_full_boundary();
        test_fill(8'hB0);
        drive_a(1'b1, 8'hEE, 1'b1, 1'b0);
        #1;
        vectors++;
        if (obs_a() !== exp_a()) begin
            $display("FAIL full_read_write got %h want %h", obs_a(), exp_a());
            miscompares++;
        end
        tick();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({a_level, a_write_ready} !== {3'd3, 1'b1}) begin
            $display("FAIL full_after got lvl=%0d wr=%b want lvl=3 wr=1", a_level, a_write_ready);
            miscompares++;
        end
        for (int i = 1; i < 4; i++) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            vectors++;
            if (a_read_data !== 8'(8'hB0 + i) || obs_a() !== exp_a()) begin
                $display("FAIL full_drain[%0d] got %h want rd=%h", i, obs_a(), 8'(8'hB0 + i));
                miscompares++;
            end
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 200; i++) begin
            b_write_valid = (i < 200);
            b_write_data  = 8'(i);
            b_read_ready  = 1'b1;
            #1;
            vectors++;
            if (obs_b() !== exp_b() || (!BYP && i > 0 && (b_read_valid !== 1'b1 || b_level !== 2'd1))) begin
                $display("FAIL back_to_back[%0d] got %h want %h", i, obs_b(), exp_b());
                miscompares++;
            end
            tick();
        end
        b_write_valid = 1'b0;
        b_read_ready  = 1'b0;
        #1;
        vectors++;
        if (b_empty !== 1'b1) begin
            $display("FAIL back_to_back_end got empty=%b want 1", b_empty);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        vectors++;
        if (obs_a() !== exp_a()) begin
            $display("FAIL flush_cycle got %h want %h", obs_a(), exp_a());
            miscompares++;
        end
        tick();
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        vectors++;
        if ({a_level, a_empty, a_read_valid} !== {3'd0, 1'b1, 1'b0}) begin
            $display("FAIL flush_after got lvl=%0d empty=%b rv=%b want 0 1 0", a_level, a_empty, a_read_valid);
            miscompares++;
        end
        tick();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        vectors++;
        if ({a_read_valid, a_level, a_write_ready} !== {1'b0, 3'd0, 1'b0} || obs_a() !== exp_a()) begin
            $display("FAIL reset_mid got %h want %h", obs_a(), exp_a());
            miscompares++;
        end
        tick();
        #3;
        reset = 1'b0;
        tick();
        drive_a(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        vectors++;
        if ({a_read_valid, a_read_data} !== {1'b1, 8'h11} || obs_a() !== exp_a()) begin
            $display("FAIL reset_recover got %h want rv=1 rd=11", obs_a());
            miscompares++;
        end
        tick();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 1000; i++) begin
            drive_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            vectors++;
            if (obs_a() !== exp_a()) begin
                $display("FAIL random[%0d] got %h want %h", i, obs_a(), exp_a());
                miscompares++;
            end
            tick();
        end
        n = 0;
        while (qa.size() > 0 && n < 10) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            vectors++;
            if (obs_a() !== exp_a()) begin
                $display("FAIL random_drain[%0d] got %h want %h", n, obs_a(), exp_a());
                miscompares++;
            end
            tick();
            n++;
        end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if (a_empty !== 1'b1 || qa.size() != 0) begin
            $display("FAIL random_empty got empty=%b model=%0d want empty=1 model=0", a_empty, qa.size());
            miscompares++;
        end
    endtask

    task automatic test_bypass();
        drive_a(1'b1, 8'h77, 1'b1, 1'b0);
        #1;
        vectors++;
        if ({a_read_valid, a_read_data} !== {1'b1, 8'h77}) begin
            $display("FAIL bypass_same_cycle got rv=%b rd=%h want rv=1 rd=77", a_read_valid, a_read_data);
            miscompares++;
        end
        tick();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({a_level, a_empty} !== {3'd0, 1'b1}) begin
            $display("FAIL bypass_level got lvl=%0d empty=%b want 0 1", a_level, a_empty);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_fill(8'hA0);
        test_drain();
        test_full_boundary();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        if (BYP) test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
